seq_word_serializer: RTL

- Upstream feeder for the serial 1101 sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on `seq`.
- A one-word holding buffer allows back-to-back words with no idle gap, so detector patterns spanning word boundaries stay intact.
- `seq` drives the detector's serial input directly.

---
 rtl/seq_ser_pkg.sv | 18 +
 rtl/seq_word_serializer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_ser_pkg.sv
// Shared definitions for the word serializer: FSM state encoding, the default
// word width and the even-parity helper used by the optional parity cycle.
package seq_ser_pkg;

  localparam int unsigned SEQ_SER_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_e;

  // Even-parity bit of a word: XOR of all bits. Narrow words are zero-extended.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/seq_word_serializer.sv
// Parallel-to-serial feeder for the 1101 sequence detector. Words arrive over
// a valid/ready handshake and leave MSB-first on seq, one bit per clock. A
// one-word hold buffer lets the next word follow with no idle cycle so that
// patterns spanning a word boundary reach the detector intact.
//
// Build option: define SEQ_SER_PARITY_EN to append an even-parity bit after
// the LSB of every word (word_done then marks the parity cycle).
//
// state  | meaning
// IDLE   | nothing to send; seq=0, seq_valid=0
// SHIFT  | data bits of the current word on seq, MSB first
// PARITY | parity bit of the current word on seq (SEQ_SER_PARITY_EN only)
module seq_word_serializer
  import seq_ser_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_SER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             seq,
  output logic             seq_valid,
  output logic             word_done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
`ifdef SEQ_SER_PARITY_EN
  logic             par_q, par_d;
`endif

  logic xfer;
  logic take_next;

  // ready is purely the registered hold flag, so no path from load_valid
  assign load_ready = ~hold_full_q;
  assign xfer       = load_valid & ~hold_full_q;

  // Next-state logic: shifting, hold-buffer capture and next-word selection
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`ifdef SEQ_SER_PARITY_EN
    par_d       = par_q;
`endif
    take_next   = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          shift_d = data_in;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SEQ_SER_PARITY_EN
          par_d   = even_parity(32'(data_in));
`endif
        end
      end
      SHIFT: begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (xfer) begin
          hold_d      = data_in;
          hold_full_d = 1'b1;
        end
        if (cnt_q == LAST_IDX) begin
`ifdef SEQ_SER_PARITY_EN
          state_d = PARITY;
`else
          take_next = 1'b1;
`endif
        end
      end
`ifdef SEQ_SER_PARITY_EN
      PARITY: begin
        take_next = 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // End of word: a held word wins, else a word arriving right now bypasses
    // the hold buffer, else go idle.
    if (take_next) begin
      cnt_d = '0;
      if (hold_full_q) begin
        shift_d     = hold_q;
        hold_full_d = 1'b0;
        state_d     = SHIFT;
`ifdef SEQ_SER_PARITY_EN
        par_d       = even_parity(32'(hold_q));
`endif
      end else if (xfer) begin
        shift_d     = data_in;
        hold_d      = hold_q;
        hold_full_d = 1'b0;
        state_d     = SHIFT;
`ifdef SEQ_SER_PARITY_EN
        par_d       = even_parity(32'(data_in));
`endif
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Output decode: seq is forced low outside active bit cycles
  always_comb begin
    seq       = 1'b0;
    seq_valid = 1'b0;
    word_done = 1'b0;
    case (state_q)
      SHIFT: begin
        seq       = shift_q[WIDTH-1];
        seq_valid = 1'b1;
`ifndef SEQ_SER_PARITY_EN
        word_done = (cnt_q == LAST_IDX);
`endif
      end
`ifdef SEQ_SER_PARITY_EN
      PARITY: begin
        seq       = par_q;
        seq_valid = 1'b1;
        word_done = 1'b1;
      end
`endif
      default: begin
        seq       = 1'b0;
        seq_valid = 1'b0;
      end
    endcase
  end

  // State, shift register, counter and hold buffer; reset drops any word in flight
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
`ifdef SEQ_SER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

endmodule
